// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU sequencer and its combinational core.
package alu_pkg;

    localparam logic [3:0] OP_MOD  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_INC  = 4'h5;
    localparam logic [3:0] OP_DEC  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_XOR  = 4'hB;
    localparam logic [3:0] OP_XNOR = 4'hC;
    localparam logic [3:0] OP_NAND = 4'hD;
    localparam logic [3:0] OP_NOR  = 4'hE;
    localparam logic [3:0] OP_NOT  = 4'hF;

    localparam logic [15:0] DIV0_RESULT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: unsigned operands, every result zero-extended to RW.
module alu_core
    import alu_pkg::*;
#(
    parameter int DW = 8,
    parameter int RW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    op,
    output logic [RW-1:0] y,
    output logic          div0
);

    logic [RW-1:0] ax;
    logic [RW-1:0] bx;
    logic          b_zero;
    logic [DW-1:0] bw;

    assign ax     = RW'(a);
    assign bx     = RW'(b);
    assign b_zero = (b == '0);

    always_comb begin
        y    = '0;
        div0 = 1'b0;
        bw   = '0;
        case (op)
            OP_MOD: begin
                // Guarded so a zero divisor never lets X reach the result.
                if (b_zero) begin
                    y    = RW'(DIV0_RESULT);
                    div0 = 1'b1;
                end else begin
                    y = RW'(a % b);
                end
            end
            OP_ADD: y = ax + bx;
            OP_SUB: y = ax - bx;
            OP_MUL: y = ax * bx;
            OP_DIV: begin
                if (b_zero) begin
                    y    = RW'(DIV0_RESULT);
                    div0 = 1'b1;
                end else begin
                    y = RW'(a / b);
                end
            end
            OP_INC: y = ax + RW'(1);
            OP_DEC: y = ax - RW'(1);
            OP_SHR: y = ax >> 1;
            OP_AND: y = ax & bx;
            OP_OR:  y = ax | bx;
            OP_SHL: y = ax << 1;
            OP_XOR: y = ax ^ bx;
            // Inverting ops are formed on DW bits so the upper half stays zero.
            OP_XNOR: begin
                bw = ~(a ^ b);
                y  = RW'(bw);
            end
            OP_NAND: begin
                bw = ~(a & b);
                y  = RW'(bw);
            end
            OP_NOR: begin
                bw = ~(a | b);
                y  = RW'(bw);
            end
            OP_NOT: begin
                bw = ~a;
                y  = RW'(bw);
            end
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Two-requester round-robin front end sharing one alu_core; one op in flight,
// grant in IDLE, compute in EXEC, hold the tagged result in RESP until accepted.
module alu_rr_sequencer
    import alu_pkg::*;
#(
    parameter int DW = 8,
    parameter int RW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    req_valid,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_b0,
    input  logic [3:0]    req_op0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b1,
    input  logic [3:0]    req_op1,
    output logic [1:0]    req_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [RW-1:0] rsp_data,
    output logic          rsp_id,
    output logic          rsp_err,
    output logic          busy
);

    state_t        state_reg, state_next;
    logic          last_id_reg, last_id_next;
    logic [DW-1:0] a_reg, a_next;
    logic [DW-1:0] b_reg, b_next;
    logic [3:0]    op_reg, op_next;
    logic          id_reg, id_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic [RW-1:0] rsp_data_reg, rsp_data_next;
    logic          rsp_id_reg, rsp_id_next;
    logic          rsp_err_reg, rsp_err_next;

    logic [RW-1:0] alu_y;
    logic          alu_div0;
    logic          grant_en;
    logic          grant_id;
    logic          any_grant;

    alu_core #(
        .DW (DW),
        .RW (RW)
    ) u_alu_core (
        .a    (a_reg),
        .b    (b_reg),
        .op   (op_reg),
        .y    (alu_y),
        .div0 (alu_div0)
    );

    assign grant_en = (state_reg == ST_IDLE) && en;

    // On contention the requester that did not win last time is preferred.
    always_comb begin
        grant_id = 1'b0;
        case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_id_reg;
            default: grant_id = 1'b0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && req_valid[gi] && (grant_id == 1'(gi));
        end
    endgenerate

    assign any_grant = |req_ready;

    always_comb begin
        state_next     = state_reg;
        last_id_next   = last_id_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        op_next        = op_reg;
        id_next        = id_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_grant) begin
                    a_next       = grant_id ? req_a1  : req_a0;
                    b_next       = grant_id ? req_b1  : req_b0;
                    op_next      = grant_id ? req_op1 : req_op0;
                    id_next      = grant_id;
                    last_id_next = grant_id;
                    state_next   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_next  = alu_y;
                rsp_err_next   = alu_div0;
                rsp_id_next    = id_reg;
                rsp_valid_next = 1'b1;
                state_next     = ST_RESP;
            end
            ST_RESP: begin
                // Returning to IDLE here means the next grant is at least one cycle later.
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            last_id_reg   <= 1'b1;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            id_reg        <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_id_reg   <= last_id_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            op_reg        <= op_next;
            id_reg        <= id_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed plus randomized bench for alu_rr_sequencer with an arithmetic reference model.
module tb_alu_rr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  req_valid;
    logic [7:0]  req_a0, req_b0, req_a1, req_b1;
    logic [3:0]  req_op0, req_op1;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        rsp_err;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int tb_last = 1;

    always #5 clk = ~clk;

    alu_rr_sequencer #(.DW(8), .RW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_op0   (req_op0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_op1   (req_op1),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {err, data} straight from the opcode table.
    function automatic logic [16:0] ref_alu(input int a, input int b, input int op);
        int r;
        logic e;
        e = 1'b0;
        r = 0;
        case (op)
            0:  if (b == 0) begin r = 'hFFFF; e = 1'b1; end else r = a % b;
            1:  r = a + b;
            2:  r = (a - b) & 'hFFFF;
            3:  r = a * b;
            4:  if (b == 0) begin r = 'hFFFF; e = 1'b1; end else r = a / b;
            5:  r = a + 1;
            6:  r = (a - 1) & 'hFFFF;
            7:  r = a / 2;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a * 2;
            11: r = a ^ b;
            12: r = (~(a ^ b)) & 'hFF;
            13: r = (~(a & b)) & 'hFF;
            14: r = (~(a | b)) & 'hFF;
            default: r = (~a) & 'hFF;
        endcase
        return {e, r[15:0]};
    endfunction

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 1) ? 2'b01 : 2'b10;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [1:0] v,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] o0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] o1,
                       input int hold);
        logic [1:0]  eg;
        logic [16:0] r;
        int waitc;
        int id;
        req_valid = v;
        req_a0 = a0; req_b0 = b0; req_op0 = o0;
        req_a1 = a1; req_b1 = b1; req_op1 = o1;
        rsp_ready = 1'b0;
        eg = exp_grant(v, tb_last);
        #1;
        waitc = 0;
        while (req_ready == 2'b00 && waitc < 5) begin
            tick();
            waitc++;
        end
        chk("grant", 32'(req_ready), 32'(eg));
        chk("issue_gap", 32'(waitc), 32'd0);
        id = eg[1] ? 1 : 0;
        tb_last = id;
        r = (id == 1) ? ref_alu(int'(a1), int'(b1), int'(o1)) : ref_alu(int'(a0), int'(b0), int'(o0));
        tick();
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
        chk("exec_no_ready", 32'(req_ready), 32'd0);
        tick();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(r[15:0]));
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_err", 32'(rsp_err), 32'(r[16]));
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'(r[15:0]));
            chk("hold_no_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        rsp_ready = 1'b0;
        $display("[TB] txn id=%0d op=%h a=%0d b=%0d data=%h err=%0b",
                 id, id ? o1 : o0, id ? a1 : a0, id ? b1 : b0, r[15:0], r[16]);
    endtask

    initial begin
        logic [1:0] rv;
        logic [7:0] ra0, rb0, ra1, rb1;
        logic [3:0] ro0, ro1;

        rst = 1'b1; en = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        req_a0 = '0; req_b0 = '0; req_op0 = '0;
        req_a1 = '0; req_b1 = '0; req_op1 = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        tb_last = 1;

        // ADD from requester 0 alone
        txn(2'b01, 8'd200, 8'd100, 4'h1, 8'd0, 8'd0, 4'h0, 0);

        // Contention: alternating grants, back-to-back every 3 cycles
        for (int k = 0; k < 4; k++)
            txn(2'b11, 8'd15, 8'd17, 4'h3, 8'd3, 8'd5, 4'h2, 0);

        // Divide by zero, then a normal modulo
        txn(2'b01, 8'd9, 8'd0, 4'h4, 8'd0, 8'd0, 4'h0, 0);
        txn(2'b01, 8'd9, 8'd4, 4'h0, 8'd0, 8'd0, 4'h0, 0);

        // Back-pressure: XNOR result held for 5 cycles with both requesters pending
        txn(2'b11, 8'hF0, 8'h0F, 4'hC, 8'hF0, 8'h0F, 4'hC, 5);

        // Enable dropped during EXEC with requester 1 pending
        req_valid = 2'b01; req_a0 = 8'd41; req_op0 = 4'h5;
        #1;
        chk("en_grant0", 32'(req_ready), 32'd1);
        tick();
        en = 1'b0; req_valid = 2'b10; req_a1 = 8'd7; req_b1 = 8'd2; req_op1 = 4'h4;
        #1;
        chk("en_exec_ready", 32'(req_ready), 32'd0);
        tick();
        chk("en_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("en_rsp_data", 32'(rsp_data), 32'd42);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tb_last = 0;
        for (int k = 0; k < 3; k++) begin
            chk("en_low_no_grant", 32'(req_ready), 32'd0);
            chk("en_low_idle", 32'(busy), 32'd0);
            tick();
        end
        en = 1'b1;
        txn(2'b10, 8'd0, 8'd0, 4'h0, 8'd7, 8'd2, 4'h4, 0);

        // Reset while a response is pending
        req_valid = 2'b10; req_a1 = 8'd5; req_b1 = 8'd6; req_op1 = 4'h1;
        #1;
        chk("rst_pre_grant", 32'(req_ready), 32'(exp_grant(2'b10, tb_last)));
        tick();
        req_valid = 2'b00;
        tick();
        chk("rst_pre_rsp", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_data", 32'(rsp_data), 32'd0);
        tb_last = 1;
        txn(2'b11, 8'd1, 8'd2, 4'h9, 8'd3, 8'd4, 4'h8, 0);
        chk("rst_last_id", 32'(tb_last), 32'd0);

        // Randomized traffic across all opcodes
        for (int n = 0; n < 40; n++) begin
            rv  = 2'($urandom_range(1, 3));
            ra0 = 8'($urandom); rb0 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            ra1 = 8'($urandom); rb1 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            ro0 = 4'($urandom); ro1 = 4'($urandom);
            txn(rv, ra0, rb0, ro0, ra1, rb1, ro1, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
